// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared read-mode constants and depth helper for fifo_sync
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_if.sv
// ============================================================================
// fifo_sync_if : write/read handshake, data and status bundle of fifo_sync
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface fifo_sync_if #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 4
);

  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo_sync_mem.sv
// ============================================================================
// fifo_sync_mem : DEPTH x DATASIZE storage, clocked write, combinational read
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 4
) (
  input  wire logic                wclk,
  input  wire logic                wclken,
  input  wire logic [ADDRSIZE-1:0] waddr,
  input  wire logic [DATASIZE-1:0] wdata,
  input  wire logic [ADDRSIZE-1:0] raddr,
  output logic      [DATASIZE-1:0] rdata
);

  localparam int c_DEPTH = fifo_depth(ADDRSIZE);

  // Storage is intentionally left unreset.
  logic [DATASIZE-1:0] r_mem [c_DEPTH];

  always_ff @(posedge wclk) begin
    if (wclken) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// fifo_sync : single-clock FIFO with count, thresholds, error pulses and a
//             registered or first-word-fall-through read port
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATASIZE     = 32,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = FIFO_MODE_REG
) (
  input  wire logic  wclk,
  input  wire logic  wrst_n,
  fifo_sync_if.slave bus
);

  localparam int                c_DEPTH     = fifo_depth(ADDRSIZE);
  localparam logic [ADDRSIZE:0] c_DEPTH_CNT = (ADDRSIZE+1)'(c_DEPTH);
  localparam logic [ADDRSIZE:0] c_AFULL     = (ADDRSIZE+1)'(AFULL_LEVEL);
  localparam logic [ADDRSIZE:0] c_AEMPTY    = (ADDRSIZE+1)'(AEMPTY_LEVEL);
  localparam logic [ADDRSIZE:0] c_ONE       = (ADDRSIZE+1)'(1);

  generate
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > c_DEPTH || AEMPTY_LEVEL < 0 ||
        AEMPTY_LEVEL >= c_DEPTH) begin : g_param_err
      $error("fifo_sync: AFULL_LEVEL must be 1..DEPTH and AEMPTY_LEVEL 0..DEPTH-1");
    end
  endgenerate

  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   r_rptr;
  logic [ADDRSIZE:0]   r_count;
  logic [ADDRSIZE:0]   w_count_next;
  logic                r_wfull;
  logic                r_rempty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic [DATASIZE-1:0] w_mem_rdata;

  // Accept decisions use only this cycle's registered flags, so a pop never
  // frees room for a same-cycle push.
  assign w_wr_ok = bus.winc & ~r_wfull;
  assign w_rd_ok = bus.rinc & ~r_rempty;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_ok) w_count_next = w_count_next + c_ONE;
    if (w_rd_ok) w_count_next = w_count_next - c_ONE;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_rempty    <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + c_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + c_ONE;
      r_count     <= w_count_next;
      r_wfull     <= (w_count_next == c_DEPTH_CNT);
      r_rempty    <= (w_count_next == '0);
      r_afull     <= (w_count_next >= c_AFULL);
      r_aempty    <= (w_count_next <= c_AEMPTY);
      r_overflow  <= bus.winc & r_wfull;
      r_underflow <= bus.rinc & r_rempty;
    end
  end

  fifo_sync_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .wclk   (wclk),
    .wclken (w_wr_ok),
    .waddr  (r_wptr[ADDRSIZE-1:0]),
    .wdata  (bus.wdata),
    .raddr  (r_rptr[ADDRSIZE-1:0]),
    .rdata  (w_mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.rdata  = w_mem_rdata;
      assign bus.rvalid = ~r_rempty;
    end else begin : g_reg
      logic [DATASIZE-1:0] r_rdata;
      logic                r_rvalid;

      always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_ok;
          if (w_rd_ok) r_rdata <= w_mem_rdata;
        end
      end

      assign bus.rdata  = r_rdata;
      assign bus.rvalid = r_rvalid;
    end
  endgenerate

  assign bus.wfull        = r_wfull;
  assign bus.rempty       = r_rempty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync.sv
// ============================================================================
// tb_fifo_sync : registered and FWFT instances driven in lockstep against a
//                queue-based reference model and a per-cycle scoreboard
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_sync;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic [DW-1:0] wdata = '0;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if_reg ();
  fifo_sync_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if_fwft ();

  assign if_reg.winc   = winc;
  assign if_reg.rinc   = rinc;
  assign if_reg.wdata  = wdata;
  assign if_fwft.winc  = winc;
  assign if_fwft.rinc  = rinc;
  assign if_fwft.wdata = wdata;

  fifo_sync #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_LEVEL(AFULL),
              .AEMPTY_LEVEL(AEMPT), .FWFT(0)) u_reg (
    .wclk   (clk),
    .wrst_n (rst_n),
    .bus    (if_reg.slave)
  );

  fifo_sync #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_LEVEL(AFULL),
              .AEMPTY_LEVEL(AEMPT), .FWFT(1)) u_fwft (
    .wclk   (clk),
    .wrst_n (rst_n),
    .bus    (if_fwft.slave)
  );

  typedef struct {
    int            count;
    bit            wfull, rempty, afull, aempty, ovf, udf, rvalid, fvalid;
    logic [DW-1:0] rdata;
    logic [DW-1:0] fdata;
  } exp_t;

  logic [DW-1:0] model[$];
  exp_t          exp_q[$];
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    exp_t e;
    bit   full, empty, wr_ok, rd_ok;
    int   n;
    @(negedge clk);
    winc = w; rinc = r; wdata = d;
    full  = (model.size() == DEPTH);
    empty = (model.size() == 0);
    wr_ok = w && !full;
    rd_ok = r && !empty;
    if (rd_ok) last_rd = model.pop_front();
    if (wr_ok) model.push_back(d);
    n = model.size();
    e.count  = n;
    e.wfull  = (n == DEPTH);
    e.rempty = (n == 0);
    e.afull  = (n >= AFULL);
    e.aempty = (n <= AEMPT);
    e.ovf    = w && full;
    e.udf    = r && empty;
    e.rvalid = rd_ok;
    e.rdata  = last_rd;
    e.fvalid = (n != 0);
    e.fdata  = (n != 0) ? model[0] : '0;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count",        32'(if_reg.count),        32'(e.count));
      chk("wfull",        32'(if_reg.wfull),        32'(e.wfull));
      chk("rempty",       32'(if_reg.rempty),       32'(e.rempty));
      chk("almost_full",  32'(if_reg.almost_full),  32'(e.afull));
      chk("almost_empty", 32'(if_reg.almost_empty), 32'(e.aempty));
      chk("overflow",     32'(if_reg.overflow),     32'(e.ovf));
      chk("underflow",    32'(if_reg.underflow),    32'(e.udf));
      chk("rvalid",       32'(if_reg.rvalid),       32'(e.rvalid));
      chk("rdata",        if_reg.rdata,             e.rdata);
      chk("fwft_count",   32'(if_fwft.count),       32'(e.count));
      chk("fwft_rvalid",  32'(if_fwft.rvalid),      32'(e.fvalid));
      chk("fwft_ovf",     32'(if_fwft.overflow),    32'(e.ovf));
      chk("fwft_udf",     32'(if_fwft.underflow),   32'(e.udf));
      if (e.fvalid) chk("fwft_rdata", if_fwft.rdata, e.fdata);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},  32'(if_reg.count),        32'd0);
    chk({tag, "_rempty"}, 32'(if_reg.rempty),       32'd1);
    chk({tag, "_aempty"}, 32'(if_reg.almost_empty), 32'd1);
    chk({tag, "_wfull"},  32'(if_reg.wfull),        32'd0);
    chk({tag, "_afull"},  32'(if_reg.almost_full),  32'd0);
    chk({tag, "_rvalid"}, 32'(if_reg.rvalid),       32'd0);
    chk({tag, "_rdata"},  if_reg.rdata,             32'd0);
    chk({tag, "_ovf"},    32'(if_reg.overflow),     32'd0);
    chk({tag, "_udf"},    32'(if_reg.underflow),    32'd0);
    chk({tag, "_f_count"},  32'(if_fwft.count),  32'd0);
    chk({tag, "_f_rvalid"}, 32'(if_fwft.rvalid), 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs before any clock edge, then hold it
  // with random requests and release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs({tag, "_async"});
    model.delete();
    exp_q.delete();
    last_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      winc = 1'($urandom_range(1)); rinc = 1'($urandom_range(1)); wdata = $urandom;
      @(posedge clk); #1;
      chk_reset_outputs({tag, "_hold"});
    end
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wp;
    do_reset("rst0");

    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'(i + 100));
    @(negedge clk);
    chk("pre_reset_count", 32'(if_reg.count), 32'd7);
    do_reset("rst_mid");

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b1, 1'b0, 32'hDEAD);
    step(1'b0, 1'b0, '0);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(200 + i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'(300 + i));
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'(400 + i));
    step(1'b1, 1'b1, 32'hBEEF);
    step(1'b0, 1'b0, '0);

    do_reset("rst_fwft");
    step(1'b1, 1'b0, 32'hA5);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 32'h5A);
    step(1'b0, 1'b0, '0);

    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) wp = (c / 400) % 3 == 0 ? 80 : ((c / 400) % 3 == 1 ? 20 : 50);
      step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)), $urandom);
    end
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
